// File: rtl/bw_io_misc_rpt_pkg.sv
// Shared constants and types for the far-end misc repeater receiver.
package bw_io_misc_rpt_pkg;

   localparam int MISC_RPT_WIDTH = 7;
   localparam int MISC_RPT_SYNC  = 2;
   localparam int MISC_RPT_FILT  = 3;

   typedef enum logic {
      RCV_IDLE,
      RCV_PRESENT
   } rcv_state_e;

endpackage

// File: rtl/bw_io_misc_rpt_filt.sv
// One repeated misc bit: synchronizer chain followed by a consecutive-sample
// deglitch filter that only accepts a new level after FILT_CNT agreeing samples.
module bw_io_misc_rpt_filt
   import bw_io_misc_rpt_pkg::*;
#(
   parameter int SYNC_STAGES = MISC_RPT_SYNC,
   parameter int FILT_CNT    = MISC_RPT_FILT,
   parameter int CNT_W       = 2
) (
   input  logic rclk,
   input  logic arst_l,
   input  logic i_din,
   output logic o_filt
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_filt;
   logic                   w_sync;

   assign w_sync = r_sync[SYNC_STAGES-1];
   assign o_filt = r_filt;

   // NOTE: all state, the synchronizer flops included, clears on reset so a
   // reset never leaves a half-shifted level that could fake a transition.
   always_ff @(posedge rclk or negedge arst_l) begin
      if (!arst_l) begin
         r_sync <= '0;
         r_cnt  <= '0;
         r_filt <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
         if (w_sync == r_filt) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_W'(FILT_CNT - 1)) begin
            r_filt <= w_sync;
            r_cnt  <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/bw_io_misc_rpt_rcv.sv
// Far-end misc repeater receiver: per-bit sync/filter, toggle accumulation and
// a valid/ack change report that holds its contents until acknowledged.
module bw_io_misc_rpt_rcv
   import bw_io_misc_rpt_pkg::*;
#(
   parameter int WIDTH       = MISC_RPT_WIDTH,
   parameter int SYNC_STAGES = MISC_RPT_SYNC,
   parameter int FILT_CNT    = MISC_RPT_FILT,
   parameter int CNT_W       = 2
) (
   input  logic             rclk,
   input  logic             arst_l,
   input  logic [WIDTH-1:0] rpt_in,
   output logic [WIDTH-1:0] rpt_out,
   output logic             chg_vld,
   output logic [WIDTH-1:0] chg_bits,
   output logic             chg_ovf,
   input  logic             chg_ack
);

   logic [WIDTH-1:0] w_filt;
   logic [WIDTH-1:0] w_tog;
   logic             w_load;
   logic [WIDTH-1:0] r_filt_d;
   logic [WIDTH-1:0] r_pend;
   logic             r_ovf_pend;
   rcv_state_e       r_state;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      bw_io_misc_rpt_filt #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILT_CNT    (FILT_CNT),
         .CNT_W       (CNT_W)
      ) u_filt (
         .rclk   (rclk),
         .arst_l (arst_l),
         .i_din  (rpt_in[gi]),
         .o_filt (w_filt[gi])
      );
   end

   assign rpt_out = w_filt;
   assign w_tog   = w_filt ^ r_filt_d;
   assign w_load  = (r_state == RCV_IDLE) && (|r_pend);

   always_ff @(posedge rclk or negedge arst_l) begin
      if (!arst_l) begin
         r_filt_d   <= '0;
         r_pend     <= '0;
         r_ovf_pend <= 1'b0;
         r_state    <= RCV_IDLE;
         chg_vld    <= 1'b0;
         chg_bits   <= '0;
         chg_ovf    <= 1'b0;
      end else begin
         r_filt_d <= w_filt;

         // A toggle landing on the load cycle starts the next report rather than
         // being swallowed by the clear.
         if (w_load) begin
            r_pend     <= w_tog;
            r_ovf_pend <= 1'b0;
         end else begin
            r_pend     <= r_pend | w_tog;
            r_ovf_pend <= r_ovf_pend | (|(w_tog & r_pend));
         end

         case (r_state)
            RCV_IDLE: begin
               if (w_load) begin
                  chg_bits <= r_pend;
                  chg_ovf  <= r_ovf_pend;
                  chg_vld  <= 1'b1;
                  r_state  <= RCV_PRESENT;
               end
            end
            RCV_PRESENT: begin
               if (chg_ack) begin
                  chg_vld  <= 1'b0;
                  chg_bits <= '0;
                  chg_ovf  <= 1'b0;
                  r_state  <= RCV_IDLE;
               end
            end
            default: r_state <= RCV_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bw_io_misc_rpt_rcv.sv
// Self-checking bench: expected reports are queued as stimulus is driven and
// compared when chg_vld rises; levels and handshake timing are checked inline.
module tb_bw_io_misc_rpt_rcv;

   localparam int W = 7;

   logic         rclk = 1'b0;
   logic         arst_l;
   logic [W-1:0] rpt_in;
   logic [W-1:0] rpt_out;
   logic         chg_vld;
   logic [W-1:0] chg_bits;
   logic         chg_ovf;
   logic         chg_ack;

   int n_tests = 0;
   int n_fail  = 0;

   logic [W:0] sb_q[$];   // {ovf, bits}
   logic [W:0] held;
   logic       prev_vld = 1'b0;

   bw_io_misc_rpt_rcv dut (
      .rclk     (rclk),
      .arst_l   (arst_l),
      .rpt_in   (rpt_in),
      .rpt_out  (rpt_out),
      .chg_vld  (chg_vld),
      .chg_bits (chg_bits),
      .chg_ovf  (chg_ovf),
      .chg_ack  (chg_ack)
   );

   always #5 rclk = ~rclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge rclk);
   endtask

   task automatic wait_vld(input string tag, input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (chg_vld) begin
            seen = 1'b1;
            break;
         end
         @(negedge rclk);
      end
      if (!seen) check(tag, 32'(seen), 32'd1);
   endtask

   task automatic do_ack(input string tag);
      chg_ack = 1'b1;
      @(negedge rclk);
      chg_ack = 1'b0;
      check(tag, 32'(chg_vld), 32'd0);
   endtask

   // Scoreboard monitor: pop on each new report, then demand stable contents.
   always @(negedge rclk) begin
      if (chg_vld && !prev_vld) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_rpt", 32'(sb_q.size()), 32'd1);
         end else begin
            logic [W:0] e;
            e = sb_q.pop_front();
            check("rpt_bits", 32'(chg_bits), 32'(e[W-1:0]));
            check("rpt_ovf", 32'(chg_ovf), 32'(e[W]));
         end
         held = {chg_ovf, chg_bits};
      end else if (chg_vld) begin
         check("rpt_hold", 32'({chg_ovf, chg_bits}), 32'(held));
      end
      prev_vld = chg_vld;
   end

   initial begin
      arst_l  = 1'b0;
      rpt_in  = '0;
      chg_ack = 1'b0;
      tick(3);
      check("rst_rpt_out", 32'(rpt_out), 32'd0);
      check("rst_vld", 32'(chg_vld), 32'd0);
      check("rst_bits", 32'(chg_bits), 32'd0);
      check("rst_ovf", 32'(chg_ovf), 32'd0);
      arst_l = 1'b1;
      tick(2);

      // All bits rise: five-cycle level latency, report two cycles later.
      rpt_in = 7'h7F;
      sb_q.push_back({1'b0, 7'h7F});
      for (int k = 1; k <= 5; k++) begin
         @(negedge rclk);
         check($sformatf("lat_rpt_out_c%0d", k), 32'(rpt_out), (k < 5) ? 32'h00 : 32'h7F);
      end
      @(negedge rclk);
      check("vld_c6", 32'(chg_vld), 32'd0);
      @(negedge rclk);
      check("vld_c7", 32'(chg_vld), 32'd1);
      do_ack("ack1_drop");

      rpt_in = 7'h00;
      sb_q.push_back({1'b0, 7'h7F});
      wait_vld("to_fall_rpt", 20);
      do_ack("ack_fall_drop");
      tick(3);

      // Two-cycle glitch on bit 0 is discarded.
      rpt_in = 7'h01;
      tick(2);
      rpt_in = 7'h00;
      tick(10);
      check("glitch_rpt_out", 32'(rpt_out), 32'h00);
      check("glitch_vld", 32'(chg_vld), 32'd0);

      rpt_in = 7'h01;
      sb_q.push_back({1'b0, 7'h01});
      tick(5);
      check("bit0_up", 32'(rpt_out), 32'h01);

      // Held report stays stable while bit 3 toggles in the background.
      wait_vld("to_rpt01", 10);
      for (int i = 0; i < 10; i++) begin
         if (i == 2) begin
            rpt_in = 7'h09;
            sb_q.push_back({1'b0, 7'h08});
         end
         @(negedge rclk);
         check("hold_bits01", 32'(chg_bits), 32'h01);
      end
      check("hold_vld", 32'(chg_vld), 32'd1);
      do_ack("gap_vld_low");
      @(negedge rclk);
      check("next_vld", 32'(chg_vld), 32'd1);
      check("next_bits", 32'(chg_bits), 32'h08);

      // Bit 5 pulses 0->1->0 while a report is held: overflow reported.
      sb_q.push_back({1'b1, 7'h20});
      rpt_in = 7'h29;
      tick(4);
      rpt_in = 7'h09;
      tick(12);
      check("pulse_rpt_out", 32'(rpt_out), 32'h09);
      check("pulse_hold_bits", 32'(chg_bits), 32'h08);
      do_ack("ack08_drop");
      wait_vld("to_ovf_rpt", 10);
      do_ack("ack_ovf_drop");
      tick(3);

      // Bit 2 toggles on the very cycle pend=0x02 is loaded: split reports.
      rpt_in = 7'h0B;
      sb_q.push_back({1'b0, 7'h02});
      sb_q.push_back({1'b0, 7'h04});
      @(negedge rclk);
      rpt_in = 7'h0F;
      wait_vld("to_split1", 20);
      do_ack("ack_split1_drop");
      wait_vld("to_split2", 10);
      do_ack("ack_split2_drop");
      tick(3);

      // Reset while presenting: everything clears, nothing reported after.
      rpt_in = 7'h00;
      sb_q.push_back({1'b0, 7'h0F});
      wait_vld("to_pre_rst_rpt", 20);
      #2 arst_l = 1'b0;
      #1;
      check("arst_vld", 32'(chg_vld), 32'd0);
      check("arst_bits", 32'(chg_bits), 32'd0);
      check("arst_ovf", 32'(chg_ovf), 32'd0);
      check("arst_rpt_out", 32'(rpt_out), 32'd0);
      @(negedge rclk);
      arst_l = 1'b1;
      tick(20);
      check("post_rst_vld", 32'(chg_vld), 32'd0);
      check("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
